// File: rtl/cmp_pkg.sv
// Shared comparator definitions: mode encoding used by the comparator, decoder and arbiter.
package cmp_pkg;

    localparam int CMP_MODE_W = 3;

    localparam logic [CMP_MODE_W-1:0] CMP_LT  = 3'b000;
    localparam logic [CMP_MODE_W-1:0] CMP_LTU = 3'b001;
    localparam logic [CMP_MODE_W-1:0] CMP_GE  = 3'b010;
    localparam logic [CMP_MODE_W-1:0] CMP_GEU = 3'b011;
    localparam logic [CMP_MODE_W-1:0] CMP_EQ  = 3'b100;
    localparam logic [CMP_MODE_W-1:0] CMP_NEQ = 3'b101;

    localparam logic PORT_BRANCH = 1'b0;
    localparam logic PORT_ALU    = 1'b1;

endpackage

// File: rtl/cmp_share_arbiter_comparator.sv
// Combinational 32-bit comparator: signed/unsigned ordering and bitwise equality by mode.
module cmp_share_arbiter_comparator
    import cmp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [CMP_MODE_W-1:0] mode,
    output logic                  result
);

    logic lt_s;
    logic ltu_s;
    logic eq_s;

    assign lt_s  = $signed(a) < $signed(b);
    assign ltu_s = a < b;
    assign eq_s  = a == b;

    // Mode select; reserved encodings return false but still produce a response upstream
    always_comb begin
        result = 1'b0;
        case (mode)
            CMP_LT:  result = lt_s;
            CMP_LTU: result = ltu_s;
            CMP_GE:  result = !lt_s;
            CMP_GEU: result = !ltu_s;
            CMP_EQ:  result = eq_s;
            CMP_NEQ: result = !eq_s;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Two-port round-robin arbiter sharing one comparator, with a single registered result stage
// and a saturating counter of request-conflict cycles.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    input  logic [CMP_MODE_W-1:0] req0_mode,
    input  logic [TAG_W-1:0]      req0_tag,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    input  logic [CMP_MODE_W-1:0] req1_mode,
    input  logic [TAG_W-1:0]      req1_tag,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp0_result,
    output logic [TAG_W-1:0]      rsp0_tag,

    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic                  rsp1_result,
    output logic [TAG_W-1:0]      rsp1_tag,

    output logic [CNT_W-1:0]      conflict_cnt
);

    logic                  s_valid_r;
    logic                  s_owner_r;
    logic [TAG_W-1:0]      s_tag_r;
    logic                  s_result_r;
    logic                  rr_last_r;
    logic [CNT_W-1:0]      conflict_cnt_r;

    logic                  rsp_fire_s;
    logic                  s_free_s;
    logic                  grant_valid_s;
    logic                  grant_id_s;
    logic                  accept_s;
    logic [DATA_W-1:0]     cmp_a_s;
    logic [DATA_W-1:0]     cmp_b_s;
    logic [CMP_MODE_W-1:0] cmp_mode_s;
    logic [TAG_W-1:0]      cmp_tag_s;
    logic                  cmp_result_s;

    assign rsp_fire_s = s_valid_r & (s_owner_r ? rsp1_ready : rsp0_ready);
    assign s_free_s   = !s_valid_r | rsp_fire_s;

    // Round-robin grant: on a tie the port that did not win last time goes first
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = PORT_BRANCH;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~rr_last_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = PORT_BRANCH;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = PORT_ALU;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = PORT_BRANCH;
        end
    end

    assign accept_s   = s_free_s & grant_valid_s;
    assign req0_ready = s_free_s & grant_valid_s & (grant_id_s == PORT_BRANCH);
    assign req1_ready = s_free_s & grant_valid_s & (grant_id_s == PORT_ALU);

    // Operand mux feeding the shared comparator
    always_comb begin
        cmp_a_s    = req0_a;
        cmp_b_s    = req0_b;
        cmp_mode_s = req0_mode;
        cmp_tag_s  = req0_tag;
        if (grant_id_s == PORT_ALU) begin
            cmp_a_s    = req1_a;
            cmp_b_s    = req1_b;
            cmp_mode_s = req1_mode;
            cmp_tag_s  = req1_tag;
        end else begin
            cmp_a_s    = req0_a;
            cmp_b_s    = req0_b;
            cmp_mode_s = req0_mode;
            cmp_tag_s  = req0_tag;
        end
    end

    cmp_share_arbiter_comparator #(
        .DATA_W (DATA_W)
    ) u_comparator (
        .a      (cmp_a_s),
        .b      (cmp_b_s),
        .mode   (cmp_mode_s),
        .result (cmp_result_s)
    );

    // Result stage: a new accept overwrites a draining entry in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_r  <= 1'b0;
            s_owner_r  <= PORT_BRANCH;
            s_tag_r    <= {TAG_W{1'b0}};
            s_result_r <= 1'b0;
            rr_last_r  <= PORT_ALU;
        end else if (accept_s) begin
            s_valid_r  <= 1'b1;
            s_owner_r  <= grant_id_s;
            s_tag_r    <= cmp_tag_s;
            s_result_r <= cmp_result_s;
            rr_last_r  <= grant_id_s;
        end else if (rsp_fire_s) begin
            s_valid_r  <= 1'b0;
        end else begin
            s_valid_r  <= s_valid_r;
        end
    end

    // Conflict counter, independent of grant, sticks at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_r <= {CNT_W{1'b0}};
        end else if (req0_valid && req1_valid && (conflict_cnt_r != {CNT_W{1'b1}})) begin
            conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign rsp0_valid   = s_valid_r & (s_owner_r == PORT_BRANCH);
    assign rsp1_valid   = s_valid_r & (s_owner_r == PORT_ALU);
    assign rsp0_result  = s_result_r;
    assign rsp1_result  = s_result_r;
    assign rsp0_tag     = s_tag_r;
    assign rsp1_tag     = s_tag_r;
    assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: a full-width instance plus a 4-bit-counter instance
// driven by the same stimulus to reach counter saturation.
module tb_cmp_share_arbiter;
    import cmp_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_mode, req1_mode;
    logic [4:0]  req0_tag, req1_tag;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic        rsp0_result, rsp1_result;
    logic [4:0]  rsp0_tag, rsp1_tag;
    logic [15:0] conflict_cnt;

    logic        sm_req0_ready, sm_req1_ready, sm_rsp0_valid, sm_rsp1_valid;
    logic        sm_rsp0_result, sm_rsp1_result;
    logic [4:0]  sm_rsp0_tag, sm_rsp1_tag;
    logic [3:0]  sm_conflict_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    cmp_share_arbiter #(.DATA_W(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_mode(req0_mode), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_mode(req1_mode), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_tag(rsp1_tag),
        .conflict_cnt(conflict_cnt)
    );

    cmp_share_arbiter #(.DATA_W(32), .TAG_W(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(sm_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_mode(req0_mode), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(sm_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_mode(req1_mode), .req1_tag(req1_tag),
        .rsp0_valid(sm_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(sm_rsp0_result), .rsp0_tag(sm_rsp0_tag),
        .rsp1_valid(sm_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(sm_rsp1_result), .rsp1_tag(sm_rsp1_tag),
        .conflict_cnt(sm_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_mode = 3'b000; req0_tag = 5'd0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_mode = 3'b000; req1_tag = 5'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp0_valid", rsp0_valid, 32'd0);
        chk("rst_rsp1_valid", rsp1_valid, 32'd0);
        chk("rst_tag", rsp0_tag, 32'd0);
        chk("rst_result", rsp0_result, 32'd0);
        chk("rst_cnt", conflict_cnt, 32'd0);
        @(negedge clk); rst = 1'b0;

        // 1: single port 0, 5 LT -3 is false
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'hFFFF_FFFD; req0_mode = CMP_LT; req0_tag = 5'd7;
        #1;
        chk("t1_req0_ready", req0_ready, 32'd1);
        chk("t1_req1_ready", req1_ready, 32'd0);
        @(posedge clk); #1;
        chk("t1_rsp0_valid", rsp0_valid, 32'd1);
        chk("t1_rsp0_result", rsp0_result, 32'd0);
        chk("t1_rsp0_tag", rsp0_tag, 32'd7);
        chk("t1_rsp1_valid", rsp1_valid, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t1_cnt", conflict_cnt, 32'd0);

        // 2: both valid every cycle; rr_last is now port 0, so port 1 wins first
        req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'd1; req0_mode = CMP_LTU; req0_tag = 5'd1;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3; req1_mode = CMP_EQ; req1_tag = 5'd2;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i % 2 == 0) begin
                chk("t2_rsp1_valid", rsp1_valid, 32'd1);
                chk("t2_rsp0_valid", rsp0_valid, 32'd0);
                chk("t2_rsp1_result", rsp1_result, 32'd1);
                chk("t2_rsp1_tag", rsp1_tag, 32'd2);
            end else begin
                chk("t2_rsp0_valid", rsp0_valid, 32'd1);
                chk("t2_rsp1_valid", rsp1_valid, 32'd0);
                chk("t2_rsp0_result", rsp0_result, 32'd0);
                chk("t2_rsp0_tag", rsp0_tag, 32'd1);
            end
            chk("t2_cnt", conflict_cnt, i + 1);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("t2_drained", rsp0_valid | rsp1_valid, 32'd0);

        // 3: stage holds port 1 under back-pressure
        @(negedge clk);
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_mode = CMP_LT; req1_tag = 5'd9;
        @(posedge clk); #1;
        chk("t3_rsp1_valid", rsp1_valid, 32'd1);
        @(negedge clk);
        req1_a = 32'd1; req1_b = 32'd2; req1_mode = CMP_GEU; req1_tag = 5'd10;
        req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0; req0_mode = CMP_EQ; req0_tag = 5'd11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_req0_ready", req0_ready, 32'd0);
            chk("t3_req1_ready", req1_ready, 32'd0);
            chk("t3_hold_valid", rsp1_valid, 32'd1);
            chk("t3_hold_result", rsp1_result, 32'd1);
            chk("t3_hold_tag", rsp1_tag, 32'd9);
            @(negedge clk);
        end
        chk("t3_cnt", conflict_cnt, 32'd7);
        rsp1_ready = 1'b1;
        #1;
        chk("t3_drain_req0_ready", req0_ready, 32'd1);
        chk("t3_drain_req1_ready", req1_ready, 32'd0);
        @(posedge clk); #1;
        chk("t3_new_rsp0_valid", rsp0_valid, 32'd1);
        chk("t3_new_rsp0_tag", rsp0_tag, 32'd11);
        chk("t3_new_rsp0_result", rsp0_result, 32'd1);
        chk("t3_new_rsp1_valid", rsp1_valid, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("t3_p1_rsp1_valid", rsp1_valid, 32'd1);
        chk("t3_p1_rsp1_tag", rsp1_tag, 32'd10);
        chk("t3_p1_rsp1_result", rsp1_result, 32'd0);
        chk("t3_p1_cnt", conflict_cnt, 32'd8);

        // 4: reserved mode returns a response with result 0
        @(negedge clk);
        req1_a = 32'd0; req1_b = 32'd0; req1_mode = 3'b111; req1_tag = 5'd3;
        @(posedge clk); #1;
        chk("t4_rsp1_valid", rsp1_valid, 32'd1);
        chk("t4_rsp1_tag", rsp1_tag, 32'd3);
        chk("t4_rsp1_result", rsp1_result, 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;

        // 5: asynchronous reset while port 0 response is pending
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_mode = CMP_EQ; req0_tag = 5'd4;
        @(posedge clk); #1;
        chk("t5_rsp0_valid_pre", rsp0_valid, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rsp0_valid_rst", rsp0_valid, 32'd0);
        chk("t5_cnt_rst", conflict_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_mode = CMP_EQ; req0_tag = 5'd5;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd0; req1_mode = CMP_LT; req1_tag = 5'd6;
        #1;
        chk("t5_tie_req0_ready", req0_ready, 32'd1);
        chk("t5_tie_req1_ready", req1_ready, 32'd0);
        @(posedge clk); #1;
        chk("t5_rsp0_valid", rsp0_valid, 32'd1);
        chk("t5_rsp0_tag", rsp0_tag, 32'd5);
        chk("t5_rsp0_result", rsp0_result, 32'd1);
        chk("t5_cnt", conflict_cnt, 32'd1);
        chk("t5_sm_cnt", sm_conflict_cnt, 32'd1);

        // 6: 20 conflict cycles since reset; 4-bit counter sticks at 15
        repeat (19) @(posedge clk);
        #1;
        chk("t6_cnt", conflict_cnt, 32'd20);
        chk("t6_sm_cnt", sm_conflict_cnt, 32'd15);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_cnt_hold", conflict_cnt, 32'd20);
        chk("t6_sm_cnt_hold", sm_conflict_cnt, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
